// File: rtl/sram_pingpong_buffer.sv
// Two-bank ping-pong tile buffer: the writer fills one bank while the reader drains the other,
// and banks change hands on commit/release.
module sram_pingpong_buffer #(
    parameter int N        = 4,
    parameter int K        = 8,
    parameter int READ_LAT = 1,
    localparam int AW      = $clog2(K),
    localparam int DW      = 8 * N * N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [N-1:0]  wr_mask,
    input  logic          wr_commit,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_release,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [1:0]    level,
    output logic [1:0]    err
);
    localparam int RW    = 8 * N;
    localparam int DEPTH = 2 << AW;

    // Handshake: a request (wr_en, wr_commit / rd_en, rd_release) is taken on the edge where
    // its side's ready is high; otherwise it is dropped and only the matching err bit records it.

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic          r_wb;
    logic          r_rb;
    logic [1:0]    r_full;
    logic [1:0]    r_err;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;

    logic          w_wr_ready;
    logic          w_rd_ready;
    logic          w_wr_acc;
    logic          w_commit_acc;
    logic          w_rd_acc;
    logic          w_rel_acc;
    logic [1:0]    w_full_next;
    logic [DW-1:0] w_rd_word;
    logic          w_out_valid;
    logic [DW-1:0] w_out_data;

    assign w_wr_ready   = !r_full[r_wb];
    assign w_rd_ready   = r_full[r_rb];
    assign w_wr_acc     = wr_en && w_wr_ready;
    assign w_commit_acc = wr_commit && w_wr_ready;
    assign w_rd_acc     = rd_en && w_rd_ready;
    assign w_rel_acc    = rd_release && w_rd_ready;
    assign w_rd_word    = r_mem[{r_rb, rd_addr}];

    // Commit and release can never hit the same bank: one needs it empty, the other full.
    always_comb begin
        w_full_next = r_full;
        if (w_commit_acc) w_full_next[r_wb] = 1'b1;
        if (w_rel_acc)    w_full_next[r_rb] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_full <= 2'b00;
            r_err  <= 2'b00;
        end else begin
            r_full <= w_full_next;
            if (w_commit_acc) r_wb <= !r_wb;
            if (w_rel_acc)    r_rb <= !r_rb;
            r_err[0] <= r_err[0] | ((wr_en | wr_commit) & !w_wr_ready);
            r_err[1] <= r_err[1] | ((rd_en | rd_release) & !w_rd_ready);
        end
    end

    // Storage is deliberately not reset; only row lanes enabled by wr_mask are written.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            for (int r = 0; r < N; r++) begin
                if (wr_mask[r]) r_mem[{r_wb, wr_addr}][RW*r +: RW] <= wr_data[RW*r +: RW];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic          r_p_valid;
            logic [DW-1:0] r_p_data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p_valid <= 1'b0;
                end else begin
                    r_p_valid <= w_rd_acc;
                    if (w_rd_acc) r_p_data <= w_rd_word;
                end
            end
            assign w_out_valid = r_p_valid;
            assign w_out_data  = r_p_data;
        end else begin : g_lat1
            assign w_out_valid = w_rd_acc;
            assign w_out_data  = w_rd_word;
        end
    endgenerate

    // Output stage holds the last returned word between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_out_valid;
            if (w_out_valid) r_rd_data <= w_out_data;
        end
    end

    assign wr_ready = w_wr_ready;
    assign rd_ready = w_rd_ready;
    assign level    = {1'b0, r_full[0]} + {1'b0, r_full[1]};
    assign err      = r_err;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
endmodule

// File: tb/tb_sram_pingpong_buffer.sv
// Directed bench for sram_pingpong_buffer: two instances (READ_LAT 1 and 2) share all inputs.
module tb_sram_pingpong_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [127:0] wr_data;
    logic [3:0]   wr_mask;
    logic         wr_commit;
    logic         rd_en;
    logic [2:0]   rd_addr;
    logic         rd_release;

    logic         o1_wr_ready, o1_rd_ready, o1_rd_valid;
    logic [127:0] o1_rd_data;
    logic [1:0]   o1_level, o1_err;
    logic         o2_wr_ready, o2_rd_ready, o2_rd_valid;
    logic [127:0] o2_rd_data;
    logic [1:0]   o2_level, o2_err;

    logic [5:0]   st1, st2;
    int           total = 0;
    int           bad   = 0;

    assign st1 = {o1_wr_ready, o1_rd_ready, o1_level, o1_err};
    assign st2 = {o2_wr_ready, o2_rd_ready, o2_level, o2_err};

    always #5 clk = ~clk;

    sram_pingpong_buffer #(.N(4), .K(8), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_commit(wr_commit), .wr_ready(o1_wr_ready), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_ready(o1_rd_ready),
        .rd_data(o1_rd_data), .rd_valid(o1_rd_valid), .level(o1_level), .err(o1_err)
    );

    sram_pingpong_buffer #(.N(4), .K(8), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_commit(wr_commit), .wr_ready(o2_wr_ready), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_ready(o2_rd_ready),
        .rd_data(o2_rd_data), .rd_valid(o2_rd_valid), .level(o2_level), .err(o2_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
        wr_addr = 0; rd_addr = 0; wr_data = '0; wr_mask = 4'hF;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        total++;
        if ({st1, st2} !== {6'b1_0_00_00, 6'b1_0_00_00}) begin
            bad++; $display("FAIL reset_status got=%b/%b exp=100000", st1, st2);
        end
        total++;
        if ({o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data} !== '0) begin
            bad++; $display("FAIL reset_rd got=%b %h / %b %h exp=0", o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data);
        end
    endtask

    task automatic test_fill_read();
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = a[2:0]; wr_data = 128'(a * 'h11); wr_mask = 4'hF;
            tick();
        end
        wr_en = 0; wr_commit = 1;
        tick();
        wr_commit = 0;
        total++;
        if ({st1, st2} !== {6'b1_1_01_00, 6'b1_1_01_00}) begin
            bad++; $display("FAIL fill_commit_status got=%b/%b exp=110100", st1, st2);
        end
        rd_en = 1; rd_addr = 5;
        tick();
        rd_en = 0;
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'h55}) begin
            bad++; $display("FAIL read5_lat1 got=%b %h exp=1 55", o1_rd_valid, o1_rd_data);
        end
        total++;
        if (o2_rd_valid !== 1'b0) begin
            bad++; $display("FAIL read5_lat2_early got=%b exp=0", o2_rd_valid);
        end
        tick();
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b0, 128'h55}) begin
            bad++; $display("FAIL read5_lat1_hold got=%b %h exp=0 55", o1_rd_valid, o1_rd_data);
        end
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'h55}) begin
            bad++; $display("FAIL read5_lat2 got=%b %h exp=1 55", o2_rd_valid, o2_rd_data);
        end
        tick();
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b0, 128'h55}) begin
            bad++; $display("FAIL read5_lat2_hold got=%b %h exp=0 55", o2_rd_valid, o2_rd_data);
        end
    endtask

    task automatic test_mask_full();
        // Bank 1 is the write bank here.
        wr_en = 1; wr_addr = 2; wr_data = '1; wr_mask = 4'hF;
        tick();
        wr_data = '0; wr_mask = 4'b0101;
        tick();
        wr_en = 0; wr_mask = 4'hF; wr_commit = 1;
        tick();
        wr_commit = 0;
        total++;
        if ({st1, st2} !== {6'b0_1_10_00, 6'b0_1_10_00}) begin
            bad++; $display("FAIL both_full_status got=%b/%b exp=011000", st1, st2);
        end
        wr_en = 1; wr_addr = 0; wr_data = 128'hDEAD;
        tick();
        wr_en = 0;
        total++;
        if ({st1, st2} !== {6'b0_1_10_01, 6'b0_1_10_01}) begin
            bad++; $display("FAIL dropped_write_err got=%b/%b exp=011001", st1, st2);
        end
        rd_en = 1; rd_addr = 0; rd_release = 1;
        tick();
        rd_en = 0; rd_release = 0;
        total++;
        if ({st1, st2} !== {6'b1_1_01_01, 6'b1_1_01_01}) begin
            bad++; $display("FAIL release_status got=%b/%b exp=110101", st1, st2);
        end
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'h0}) begin
            bad++; $display("FAIL read_release_lat1 got=%b %h exp=1 0", o1_rd_valid, o1_rd_data);
        end
        tick();
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'h0}) begin
            bad++; $display("FAIL read_release_lat2 got=%b %h exp=1 0", o2_rd_valid, o2_rd_data);
        end
        rd_en = 1; rd_addr = 2;
        tick();
        rd_en = 0;
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000}) begin
            bad++; $display("FAIL mask_lat1 got=%b %h", o1_rd_valid, o1_rd_data);
        end
        tick();
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000}) begin
            bad++; $display("FAIL mask_lat2 got=%b %h", o2_rd_valid, o2_rd_data);
        end
    endtask

    task automatic test_swap();
        // Entry: bank1 full, wb=0, rb=1.
        wr_en = 1; wr_addr = 7; wr_data = 128'h77AA;
        tick();
        wr_en = 0; wr_commit = 1; rd_release = 1;
        tick();
        wr_commit = 0; rd_release = 0;
        total++;
        if ({st1, st2} !== {6'b1_1_01_01, 6'b1_1_01_01}) begin
            bad++; $display("FAIL swap1_status got=%b/%b exp=110101", st1, st2);
        end
        wr_en = 1; wr_addr = 3; wr_data = 128'h1234; rd_en = 1; rd_addr = 7;
        tick();
        wr_en = 0; rd_en = 0;
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'h77AA}) begin
            bad++; $display("FAIL swap1_read_lat1 got=%b %h exp=1 77aa", o1_rd_valid, o1_rd_data);
        end
        wr_commit = 1; rd_release = 1;
        tick();
        wr_commit = 0; rd_release = 0;
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'h77AA}) begin
            bad++; $display("FAIL swap1_read_lat2 got=%b %h exp=1 77aa", o2_rd_valid, o2_rd_data);
        end
        total++;
        if ({st1, st2} !== {6'b1_1_01_01, 6'b1_1_01_01}) begin
            bad++; $display("FAIL swap2_status got=%b/%b exp=110101", st1, st2);
        end
        rd_en = 1; rd_addr = 3;
        tick();
        rd_en = 0;
        total++;
        if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'h1234}) begin
            bad++; $display("FAIL swap2_read_lat1 got=%b %h exp=1 1234", o1_rd_valid, o1_rd_data);
        end
        tick();
        total++;
        if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'h1234}) begin
            bad++; $display("FAIL swap2_read_lat2 got=%b %h exp=1 1234", o2_rd_valid, o2_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1;
        tick();
        rst = 0; rd_en = 1; rd_addr = 0;
        tick();
        rd_en = 0;
        total++;
        if ({st1, st2} !== {6'b1_0_00_10, 6'b1_0_00_10}) begin
            bad++; $display("FAIL read_at_reset_err got=%b/%b exp=100010", st1, st2);
        end
        total++;
        if ({o1_rd_valid, o2_rd_valid} !== 2'b00) begin
            bad++; $display("FAIL read_at_reset_valid got=%b%b exp=00", o1_rd_valid, o2_rd_valid);
        end
        tick();
        total++;
        if ({o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data} !== '0) begin
            bad++; $display("FAIL read_at_reset_late got=%b %h / %b %h exp=0", o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data);
        end
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = a[2:0]; wr_data = 128'('h100 + a);
            tick();
        end
        wr_en = 0; wr_commit = 1;
        tick();
        wr_commit = 0;
        total++;
        if ({st1, st2} !== {6'b1_1_01_10, 6'b1_1_01_10}) begin
            bad++; $display("FAIL b2b_commit_status got=%b/%b exp=110110", st1, st2);
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = i[2:0];
            tick();
            total++;
            if ({o1_rd_valid, o1_rd_data} !== {1'b1, 128'('h100 + i)}) begin
                bad++; $display("FAIL b2b_lat1_%0d got=%b %h exp=1 %h", i, o1_rd_valid, o1_rd_data, 128'('h100 + i));
            end
            if (i > 0) begin
                total++;
                if ({o2_rd_valid, o2_rd_data} !== {1'b1, 128'('h100 + i - 1)}) begin
                    bad++; $display("FAIL b2b_lat2_%0d got=%b %h exp=1 %h", i, o2_rd_valid, o2_rd_data, 128'('h100 + i - 1));
                end
            end
        end
        rst = 1; rd_en = 1; rd_addr = 4;
        tick();
        rst = 0; rd_en = 0;
        total++;
        if ({st1, st2} !== {6'b1_0_00_00, 6'b1_0_00_00}) begin
            bad++; $display("FAIL midstream_reset_status got=%b/%b exp=100000", st1, st2);
        end
        total++;
        if ({o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data} !== '0) begin
            bad++; $display("FAIL midstream_reset_rd got=%b %h / %b %h exp=0", o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data);
        end
        tick();
        total++;
        if ({o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data} !== '0) begin
            bad++; $display("FAIL inflight_suppressed got=%b %h / %b %h exp=0", o1_rd_valid, o1_rd_data, o2_rd_valid, o2_rd_data);
        end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_fill_read();
        test_mask_full();
        test_swap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_pingpong_buffer.md
SRAM_PINGPONG_BUFFER -- requirements
Module: sram_pingpong_buffer

Interface
REQ-001 Parameter N, default 4, tile dimension; each entry is 8*N*N bits, organised as N rows of 8*N bits (row r = bits [8*N*(r+1)-1 : 8*N*r]).
REQ-002 Parameter K, default 8, entries per bank; address width AW = $clog2(K).
REQ-003 Parameter READ_LAT, default 1, read latency in cycles; legal values 1 and 2 only.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write request to the current write bank.
REQ-007 wr_addr  input  AW  write entry address.
REQ-008 wr_data  input  8*N*N  write data.
REQ-009 wr_mask  input  N  per-row write enable; bit r gates row r.
REQ-010 wr_commit  input  1  marks the current write bank full and hands it to the reader.
REQ-011 wr_ready  output  1  current write bank is not full; writes and commits are accepted.
REQ-012 rd_en  input  1  read request from the current read bank.
REQ-013 rd_addr  input  AW  read entry address.
REQ-014 rd_release  input  1  reader finished with the current read bank.
REQ-015 rd_ready  output  1  current read bank is full and readable.
REQ-016 rd_data  output  8*N*N  read data, valid when rd_valid=1.
REQ-017 rd_valid  output  1  one-cycle pulse per accepted read.
REQ-018 level  output  2  number of full banks (0..2).
REQ-019 err  output  2  sticky flags: bit0 = write/commit while !wr_ready; bit1 = read/release while !rd_ready.

Function
REQ-020 The block SHALL hold two banks of K entries, a 1-bit write-bank pointer wb, a 1-bit read-bank pointer rb, and a per-bank full flag full[1:0].
REQ-021 wr_ready SHALL equal !full[wb]; rd_ready SHALL equal full[rb]; level SHALL equal full[0]+full[1]; all three combinational from registered state.
REQ-022 A write is accepted when wr_en=1 and wr_ready=1; at the next edge rows r with wr_mask[r]=1 of bank wb, entry wr_addr, SHALL take wr_data row r; unmasked rows SHALL hold.
REQ-023 wr_commit accepted (wr_ready=1) SHALL set full[wb] and toggle wb at the next edge; a write accepted in the same cycle SHALL land in the old wb.
REQ-024 A read is accepted when rd_en=1 and rd_ready=1; rd_data SHALL present entry rd_addr of bank rb, and rd_valid SHALL pulse, exactly READ_LAT cycles later.
REQ-025 rd_release accepted (rd_ready=1) SHALL clear full[rb] and toggle rb at the next edge; a read accepted in the same cycle SHALL be serviced from the old rb.
REQ-026 Commit of bank X and release of bank Y in the same cycle SHALL both take effect; level updates accordingly.
REQ-027 Reads and writes never target the same bank in one cycle (write needs !full, read needs full); no bypass logic is required.
REQ-028 Writes, commits, reads or releases that are not accepted SHALL be dropped with no state change except the err flags.
REQ-029 err[0] SHALL set on wr_en or wr_commit with wr_ready=0; err[1] SHALL set on rd_en or rd_release with rd_ready=0; cleared only by rst.
REQ-030 rd_data SHALL hold its last value when rd_valid=0.
REQ-031 Throughput: one write and one read per cycle sustained; no bubbles at bank swap.

Reset
REQ-032 While rst=1 at an edge: wb=0, rb=0, full=00, rd_valid=0, rd_data=0, err=00, read pipeline flushed; storage contents are not reset.
REQ-033 After reset: wr_ready=1, rd_ready=0, level=0.
REQ-034 rst asserted with a read in flight SHALL suppress its rd_valid pulse.

Verification (N=4, K=8)
REQ-035 Reset, write addr 0..7 data=addr*0x11 full mask, commit -> level=1, rd_ready=1, wr_ready=1, wb=1; read addr 5 -> rd_data=0x55 (zero-extended), rd_valid exactly READ_LAT cycles later.
REQ-036 Write 0xFF..FF addr 2, then write 0 with wr_mask=0101 -> read returns rows 1,3 = all-ones, rows 0,2 = zero.
REQ-037 Commit both banks without release -> level=2, wr_ready=0; extra wr_en -> dropped, err=01; release -> level=1, wr_ready=1.
REQ-038 rd_en at reset -> no rd_valid, err=10; same-cycle rd_en+rd_release on full bank -> data from old bank, then rb toggles.
REQ-039 Same-cycle wr_commit (bank 1) and rd_release (bank 0) with level=1 -> level stays 1, rb=1, wb=0.
REQ-040 Back-to-back reads every cycle for READ_LAT=1 and 2, rst pulsed mid-stream -> in-flight rd_valid suppressed, outputs at reset values.
